// File: rtl/sent_pkg.sv
// rtl/sent_pkg.sv - shared types and constants for the SENT transmit frame builder
package sent_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CRC,
    ST_SYNC,
    ST_STAT,
    ST_DATA,
    ST_CRCO
  } sent_state_e;

  localparam logic [1:0] NIB_SYNC   = 2'd0;
  localparam logic [1:0] NIB_STATUS = 2'd1;
  localparam logic [1:0] NIB_DATA   = 2'd2;
  localparam logic [1:0] NIB_CRC    = 2'd3;

  // x^4+x^3+x^2+1 with the implicit x^4 term dropped
  localparam logic [3:0] CRC_POLY         = 4'hD;
  localparam logic [3:0] CRC_SEED_DEFAULT = 4'h5;

  localparam logic [2:0] LAST_DATA_IDX = 3'd5;
  localparam logic [2:0] CRC_LAST_STEP = 3'd7;

  // D1..D6 of a fast-channel frame; D4/D5 carry the rolling frame counter
  function automatic logic [3:0] data_nibble(
    input logic [13:0] f1,
    input logic [5:0]  cnt,
    input logic [2:0]  idx,
    input logic        inv_en
  );
    logic [3:0] nib;
    case (idx)
      3'd0:    nib = f1[13:10];
      3'd1:    nib = f1[9:6];
      3'd2:    nib = f1[5:2];
      3'd3:    nib = {f1[1:0], cnt[5:4]};
      3'd4:    nib = cnt[3:0];
      3'd5:    nib = inv_en ? ~f1[13:10] : 4'h0;
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/sent_crc4.sv
// rtl/sent_crc4.sv - one nibble step of the SENT CRC-4 (shift by four, then fold in the nibble)
module sent_crc4
  import sent_pkg::*;
(
  input  logic [3:0] crc_in,
  input  logic [3:0] nibble,
  output logic [3:0] crc_out
);

  logic [3:0] shifted;

  always_comb begin
    shifted = crc_in;
    for (int i = 0; i < 4; i++) begin
      shifted = shifted[3] ? ({shifted[2:0], 1'b0} ^ CRC_POLY) : {shifted[2:0], 1'b0};
    end
    crc_out = shifted ^ nibble;
  end

endmodule

// File: rtl/sent_tx_frame_builder.sv
// rtl/sent_tx_frame_builder.sv - requests a 14-bit word, precomputes its CRC, then streams the nine-nibble SENT frame
module sent_tx_frame_builder
  import sent_pkg::*;
#(
  parameter logic [3:0] CRC_SEED      = CRC_SEED_DEFAULT,
  parameter bit         INV_NIBBLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  status_in,
  output logic        load_14bit,
  input  logic [13:0] f1_14bit,
  input  logic        done,
  output logic [3:0]  nib_data,
  output logic [1:0]  nib_type,
  output logic        nib_valid,
  input  logic        nib_ready,
  output logic [5:0]  frame_cnt
);

  sent_state_e state, state_next;

  logic [13:0] f1_q;
  logic [3:0]  status_q;
  logic [3:0]  crc_q;
  logic [3:0]  crc_next;
  logic [3:0]  crc_nib;
  logic [3:0]  cur_data;
  logic [2:0]  nib_idx;
  logic [2:0]  crc_step;

  assign cur_data = data_nibble(f1_q, frame_cnt, nib_idx, INV_NIBBLE_EN);
  // Final CRC step folds in the zero augment nibble instead of data
  assign crc_nib  = (crc_step == CRC_LAST_STEP) ? 4'h0 : cur_data;

  sent_crc4 u_crc4 (
    .crc_in  (crc_q),
    .nibble  (crc_nib),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_14bit = 1'b0;
    nib_valid  = 1'b0;
    nib_data   = 4'h0;
    nib_type   = NIB_SYNC;
    case (state)
      ST_IDLE: begin
        if (enable) state_next = ST_REQ;
      end
      ST_REQ: begin
        load_14bit = 1'b1;
        if (done) state_next = ST_CRC;
      end
      ST_CRC: begin
        if (crc_step == CRC_LAST_STEP) state_next = ST_SYNC;
      end
      ST_SYNC: begin
        nib_valid = 1'b1;
        nib_type  = NIB_SYNC;
        if (nib_ready) state_next = ST_STAT;
      end
      ST_STAT: begin
        nib_valid = 1'b1;
        nib_type  = NIB_STATUS;
        nib_data  = status_q;
        if (nib_ready) state_next = ST_DATA;
      end
      ST_DATA: begin
        nib_valid = 1'b1;
        nib_type  = NIB_DATA;
        nib_data  = cur_data;
        if (nib_ready && nib_idx == LAST_DATA_IDX) state_next = ST_CRCO;
      end
      ST_CRCO: begin
        nib_valid = 1'b1;
        nib_type  = NIB_CRC;
        nib_data  = crc_q;
        if (nib_ready) state_next = enable ? ST_REQ : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Step 0 of the CRC phase reloads the seed; steps 1..6 cover D1..D6, step 7 the augment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f1_q      <= 14'h0;
      status_q  <= 4'h0;
      crc_q     <= CRC_SEED;
      frame_cnt <= 6'd0;
      nib_idx   <= 3'd0;
      crc_step  <= 3'd0;
    end else begin
      case (state)
        ST_REQ: begin
          if (done) begin
            f1_q     <= f1_14bit;
            status_q <= status_in;
            nib_idx  <= 3'd0;
            crc_step <= 3'd0;
          end
        end
        ST_CRC: begin
          crc_step <= crc_step + 3'd1;
          if (crc_step == 3'd0) begin
            crc_q <= CRC_SEED;
          end else begin
            crc_q <= crc_next;
          end
          if (crc_step != 3'd0 && crc_step != CRC_LAST_STEP) begin
            nib_idx <= (nib_idx == LAST_DATA_IDX) ? 3'd0 : nib_idx + 3'd1;
          end
        end
        ST_DATA: begin
          if (nib_ready) begin
            nib_idx <= (nib_idx == LAST_DATA_IDX) ? 3'd0 : nib_idx + 3'd1;
          end
        end
        ST_CRCO: begin
          if (nib_ready) frame_cnt <= frame_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sent_tx_frame_builder.md
SENT_TX_FRAME_BUILDER -- requirements
Module: sent_tx_frame_builder

Interface
REQ-001 Parameter CRC_SEED, default 4'h5, CRC-4 initial value.
REQ-002 Parameter INV_NIBBLE_EN, default 1; 1: D6 = ~f1_14bit[13:10], 0: D6 = 4'h0.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 enable  input  1  level; 1 starts/continues frame generation.
REQ-006 status_in  input  4  status/communication nibble, sampled at data capture.
REQ-007 load_14bit  output  1  request to upstream 14-bit packer; held high until done.
REQ-008 f1_14bit  input  14  fast-channel word from packer.
REQ-009 done  input  1  one-cycle strobe; f1_14bit valid at the rising edge where done=1.
REQ-010 nib_data  output  4  nibble value to pulse generator.
REQ-011 nib_type  output  2  0=sync, 1=status, 2=data, 3=crc.
REQ-012 nib_valid  output  1  nibble offered; nib_data/nib_type stable while nib_valid && !nib_ready.
REQ-013 nib_ready  input  1  pulse generator accepts the nibble on the edge where nib_valid && nib_ready.
REQ-014 frame_cnt  output  6  count of completed frames.

Function
REQ-015 FSM states: IDLE, REQ, CRC, SYNC, STAT, DATA, CRCO.
REQ-016 IDLE: when enable=1, go to REQ; load_14bit=0 and nib_valid=0 in IDLE.
REQ-017 REQ: load_14bit=1; on the edge with done=1, capture f1_14bit and status_in, deassert load_14bit next cycle, go to CRC.
REQ-018 Data nibbles: D1..D6 = {f1[13:10], f1[9:6], f1[5:2], {f1[1:0], frame_cnt[5:4]}, frame_cnt[3:0], D6 per REQ-002}.
REQ-019 CRC: polynomial x^4+x^3+x^2+1, seed CRC_SEED, one nibble per cycle over D1..D6 then one 4'h0 augment nibble (7 cycles); status nibble excluded.
REQ-020 SYNC: offer nib_type=0, nib_data=0; then STAT offers status, DATA offers D1..D6 in order, CRCO offers the CRC; each advances only on handshake.
REQ-021 At CRCO handshake: frame_cnt increments (63 wraps to 0); go to REQ if enable=1, else IDLE.
REQ-022 enable deasserted mid-frame: current frame completes through CRCO; no truncated frames.
REQ-023 done outside REQ: ignored, no capture.
REQ-024 nib_ready held high continuously: one nibble per cycle, 9 nibbles per frame back-to-back.
REQ-025 Latency: first SYNC nib_valid exactly 8 cycles after the capturing done edge (1 + 7 CRC cycles).
REQ-026 Internal nibble index wraps 5->0 only on CRC or state exit; no out-of-range index reachable.

Reset
REQ-027 reset asserted: state=IDLE, load_14bit=0, nib_valid=0, nib_data=0, nib_type=0, frame_cnt=0, captured data=0, CRC register=CRC_SEED.
REQ-028 Reset mid-frame aborts immediately; partial frame discarded, frame_cnt not incremented.

Structure
REQ-029 Shared package sent_pkg: state enum, nibble-type codes, CRC polynomial constant, default seed.
REQ-030 One sub-module sent_crc4: combinational nibble-step CRC (crc_in, nibble -> crc_out); FSM owns the register.

Verification
REQ-031 f1=14'h3FFF, cnt=0, status=4'h0, ready=1 -> nibbles 0,0,F,F,F,C,0,0 then CRC of {F,F,F,C,0,0}+augment matching reference model.
REQ-032 f1=14'h0000, status=4'hA, INV_NIBBLE_EN=1 -> D6=F, status nibble=A, nib_type sequence 0,1,2,2,2,2,2,2,3.
REQ-033 nib_ready low 5 cycles on D3 -> nib_valid, nib_data, nib_type held constant all 5 cycles, no nibble skipped.
REQ-034 Run 64 frames -> frame_cnt 63 then 0; D4[1:0]/D5 reflect the wrapped count.
REQ-035 enable dropped during D2 -> frame completes through CRC, then IDLE, load_14bit stays 0.
REQ-036 reset pulsed during DATA -> all outputs at reset values next edge; after release with enable=1, first SYNC follows fresh REQ/done, frame_cnt=0.
